// File: rtl/mips_cpu_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_muldiv_pkg
// Purpose  : Shared op codes, FSM state type and op-decode helpers for the
//            iterative multiply/divide sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package mips_cpu_muldiv_pkg;

  // Op codes match the ALU control encoding used by decode
  localparam logic [3:0] OP_MULT  = 4'b0000;
  localparam logic [3:0] OP_MULTU = 4'b1001;
  localparam logic [3:0] OP_DIV   = 4'b1101;
  localparam logic [3:0] OP_DIVU  = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } muldiv_state_t;

  function automatic logic op_is_valid(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_div(input logic [3:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_cpu_muldiv_if.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_muldiv_if
// Purpose  : Execute-stage bus between the CPU pipeline and the mul/div unit.
//            master = pipeline side, slave = mul/div sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface mips_cpu_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cancel;
  logic             mthi;
  logic             mtlo;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, op1, op2, cancel, mthi, mtlo, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, op1, op2, cancel, mthi, mtlo, wdata,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mips_cpu_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_muldiv_step
// Purpose  : One combinational iteration of the mul/div loop.
//            Multiply: acc = {partial product, remaining multiplier bits};
//                      add operand on acc[0], then shift right (LSB first).
//            Divide  : acc = {remainder, remaining dividend bits};
//                      shift left, trial-subtract operand, restore on borrow.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_muldiv_step #(
  parameter int WIDTH = 32
) (
  input  wire logic               i_div,
  input  wire logic [2*WIDTH-1:0] i_acc,
  input  wire logic [WIDTH-1:0]   i_operand,
  output logic      [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift_hi;
  logic             w_less;
  logic [WIDTH-1:0] w_diff;

  // Single shift-add or restoring-divide iteration
  always_comb begin
    w_sum      = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + (i_acc[0] ? {1'b0, i_operand} : '0);
    // Shifted remainder needs one extra bit: remainder < divisor may use bit WIDTH-1
    w_shift_hi = i_acc[2*WIDTH-1:WIDTH-1];
    w_less     = (w_shift_hi < {1'b0, i_operand});
    // Only consumed when no borrow, so the result fits in WIDTH bits
    w_diff     = w_shift_hi[WIDTH-1:0] - i_operand;
    if (i_div) begin
      if (w_less) o_acc = {w_shift_hi[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      else        o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc = {w_sum, i_acc[WIDTH-1:1]};
    end
  end

endmodule
`default_nettype wire

// File: rtl/mips_cpu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : mips_cpu_muldiv_seq
// Purpose  : Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
//            Operates on magnitudes for WIDTH iterations, then applies sign
//            correction in one FIX cycle before writing HI/LO.
// Revision : 1.0 - initial release
// ============================================================================
module mips_cpu_muldiv_seq
  import mips_cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  wire logic          clk,
  input  wire logic          reset,
  mips_cpu_muldiv_if.slave   bus
);

  localparam int CW = $clog2(WIDTH);

  muldiv_state_t      r_state;
  muldiv_state_t      w_next;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_step_acc;
  logic [WIDTH-1:0]   r_operand;
  logic               r_div;
  logic               r_neg_q;   // product / quotient must be negated
  logic               r_neg_r;   // remainder takes the dividend's sign
  logic               r_div0;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;

  logic               w_start;
  logic               w_sgn;
  logic [WIDTH-1:0]   w_mag1;
  logic [WIDTH-1:0]   w_mag2;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_start = bus.start && !bus.cancel && op_is_valid(bus.op);
  assign w_sgn   = op_is_signed(bus.op);
  assign w_mag1  = (w_sgn && bus.op1[WIDTH-1]) ? -bus.op1 : bus.op1;
  assign w_mag2  = (w_sgn && bus.op2[WIDTH-1]) ? -bus.op2 : bus.op2;

  mips_cpu_muldiv_step #(.WIDTH(WIDTH)) u_step (
    .i_div     (r_div),
    .i_acc     (r_acc),
    .i_operand (r_operand),
    .o_acc     (w_step_acc)
  );

  // Sign correction of the magnitude result. With a zero divisor the loop
  // leaves |op1| as remainder, so re-signing it restores op1 exactly.
  always_comb begin
    w_prod   = r_neg_q ? -r_acc : r_acc;
    w_quot   = r_div0 ? '1 : (r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
    w_rem    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
    w_res_hi = r_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
    w_res_lo = r_div ? w_quot : w_prod[WIDTH-1:0];
  end

  // Next-state logic: IDLE -> RUN -> FIX -> IDLE, cancel aborts to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_next = RUN;
      RUN:     if (bus.cancel) w_next = IDLE;
               else if (r_count == CW'(WIDTH - 1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Operand capture on issue and one loop iteration per RUN cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc     <= '0;
      r_count   <= '0;
      r_operand <= '0;
      r_div     <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_div0    <= 1'b0;
    end else if (r_state == IDLE) begin
      if (w_start) begin
        // Low half of acc is preloaded with the bits the loop consumes
        r_acc     <= {{WIDTH{1'b0}}, op_is_div(bus.op) ? w_mag1 : w_mag2};
        r_operand <= op_is_div(bus.op) ? w_mag2 : w_mag1;
        r_div     <= op_is_div(bus.op);
        r_neg_q   <= w_sgn && (bus.op1[WIDTH-1] ^ bus.op2[WIDTH-1]);
        r_neg_r   <= w_sgn && bus.op1[WIDTH-1];
        r_div0    <= op_is_div(bus.op) && (bus.op2 == '0);
        r_count   <= '0;
      end
    end else if (r_state == RUN && !bus.cancel) begin
      r_acc   <= w_step_acc;
      r_count <= r_count + 1'b1;
    end
  end

  // HI/LO: MTHI/MTLO in IDLE, op result at end of FIX, done pulse follows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE && !bus.cancel) begin
        if (bus.mthi) r_hi <= bus.wdata;
        if (bus.mtlo) r_lo <= bus.wdata;
      end else if (r_state == FIX && !bus.cancel) begin
        r_hi   <= w_res_hi;
        r_lo   <= w_res_lo;
        r_done <= 1'b1;
      end
    end
  end

  assign bus.busy = (r_state != IDLE);
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_cpu_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_cpu_muldiv_seq
// Purpose  : Self-checking bench for the mul/div sequencer; results compared
//            against a 64-bit arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_cpu_muldiv_seq;
  import mips_cpu_muldiv_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mips_cpu_muldiv_if #(.WIDTH(32)) bus ();

  mips_cpu_muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Architectural reference: plain 64-bit arithmetic
  function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                inout logic [31:0] hi, inout logic [31:0] lo);
    longint      sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      OP_MULT:  begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
      OP_MULTU: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
      OP_DIV: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      OP_DIVU: begin
        if (b == 0) begin lo = '1; hi = a; end
        else begin lo = a / b; hi = a % b; end
      end
      default: ;
    endcase
  endfunction

  // Issue one op, observe 36 cycles, check latency, busy span, done pulse and result.
  // poke: re-assert start with another op while busy; it must be ignored.
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
    int n_busy = 0, n_done = 0, done_at = -1;
    logic [31:0] old_hi = m_hi, old_lo = m_lo;
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.op1 = a; bus.op2 = b;
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (poke && i == 5) begin bus.start = 1'b1; bus.op = OP_MULTU; bus.op1 = 32'h1234_5678; bus.op2 = 32'h9; end
      if (poke && i == 6) bus.start = 1'b0;
      if (bus.busy) n_busy++;
      if (bus.done) begin n_done++; if (done_at < 0) done_at = i; end
      if (i == 16) begin
        check({tag, "_midhi"}, bus.hi, old_hi);
        check({tag, "_midlo"}, bus.lo, old_lo);
      end
    end
    model(op, a, b, m_hi, m_lo);
    check({tag, "_busycyc"}, 32'(n_busy), 32'd33);
    check({tag, "_donecnt"}, 32'(n_done), 32'd1);
    check({tag, "_doneat"}, 32'(done_at), 32'd33);
    check({tag, "_hi"}, bus.hi, m_hi);
    check({tag, "_lo"}, bus.lo, m_lo);
  endtask

  initial begin
    logic [3:0]  ops [4];
    logic [31:0] ra, rb;
    logic [3:0]  rop;
    int          n_done;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU};

    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.op1 = '0; bus.op2 = '0;
    bus.cancel = 1'b0; bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    check("rst_hi", bus.hi, 32'h0);
    check("rst_lo", bus.lo, 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_done", 32'(bus.done), 32'h0);
    reset = 1'b0;

    // Directed ops with spec-given results
    issue("mult_m3x7", OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0);
    check("mult_m3x7_lit", bus.lo, 32'hFFFF_FFEB);
    issue("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    check("multu_max_lit", bus.hi, 32'hFFFF_FFFE);
    issue("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0);
    check("div_m7_2_lit", bus.lo, 32'hFFFF_FFFD);
    issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    check("div_ovf_lit", bus.lo, 32'h8000_0000);
    issue("divu_5_0", OP_DIVU, 32'd5, 32'd0, 1'b0);
    check("divu_5_0_lit", bus.hi, 32'd5);
    issue("div_neg_0", OP_DIV, 32'hFFFF_FF00, 32'd0, 1'b0);
    issue("start_busy", OP_DIV, 32'd1000, 32'hFFFF_FFFD, 1'b1);

    // Randomized ops, occasional zero divisor
    for (int k = 0; k < 16; k++) begin
      rop = ops[$urandom_range(0, 3)];
      ra  = $urandom;
      rb  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (k[0]) rb = rb >> $urandom_range(0, 31);
      issue("rand", rop, ra, rb, 1'b0);
    end

    // MTHI alone, then MTHI+MTLO together
    @(negedge clk); bus.mthi = 1'b1; bus.wdata = 32'h0000_1234;
    @(negedge clk); bus.mthi = 1'b0; m_hi = 32'h0000_1234;
    check("mthi_hi", bus.hi, m_hi);
    check("mthi_lo", bus.lo, m_lo);
    bus.mthi = 1'b1; bus.mtlo = 1'b1; bus.wdata = 32'hCAFE_F00D;
    @(negedge clk); bus.mthi = 1'b0; bus.mtlo = 1'b0; m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
    check("mthilo_hi", bus.hi, m_hi);
    check("mthilo_lo", bus.lo, m_lo);

    // Invalid op is ignored
    bus.start = 1'b1; bus.op = 4'b0110; bus.op1 = 32'd3; bus.op2 = 32'd4;
    @(negedge clk); bus.start = 1'b0;
    check("inval_busy", 32'(bus.busy), 32'h0);

    // Cancel in IDLE suppresses start, and a cancelled mthi is dropped
    bus.start = 1'b1; bus.op = OP_MULT; bus.cancel = 1'b1; bus.mthi = 1'b1; bus.wdata = 32'h5555_5555;
    @(negedge clk); bus.start = 1'b0; bus.cancel = 1'b0; bus.mthi = 1'b0;
    check("cancel_idle_busy", 32'(bus.busy), 32'h0);
    check("cancel_idle_hi", bus.hi, m_hi);

    // Cancel an in-flight DIVU at cycle 10
    bus.start = 1'b1; bus.op = OP_DIVU; bus.op1 = 32'd100; bus.op2 = 32'd7;
    @(negedge clk); bus.start = 1'b0;
    repeat (8) @(negedge clk);
    check("cancel_pre_busy", 32'(bus.busy), 32'h1);
    bus.cancel = 1'b1; bus.mthi = 1'b1; bus.wdata = 32'h7777_7777;
    @(negedge clk); bus.cancel = 1'b0; bus.mthi = 1'b0;
    check("cancel_busy", 32'(bus.busy), 32'h0);
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("cancel_nodone", 32'(n_done), 32'h0);
    check("cancel_hi", bus.hi, m_hi);
    check("cancel_lo", bus.lo, m_lo);

    // Asynchronous reset 20 cycles into a run
    bus.start = 1'b1; bus.op = OP_MULTU; bus.op1 = 32'hDEAD_BEEF; bus.op2 = 32'h1234_5678;
    @(negedge clk); bus.start = 1'b0;
    repeat (19) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_busy", 32'(bus.busy), 32'h0);
    check("arst_hi", bus.hi, 32'h0);
    check("arst_lo", bus.lo, 32'h0);
    @(negedge clk); reset = 1'b0; m_hi = '0; m_lo = '0;
    repeat (40) @(negedge clk);
    check("arst_after_busy", 32'(bus.busy), 32'h0);
    check("arst_after_lo", bus.lo, m_lo);

    issue("post_rst", OP_MULT, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
